text_ram_writer: RTL and testbench
==================================

Name: text_ram_writer

Overview:
- Consumes character writes delivered by the I2C register block and commits them to the text-mode video RAM.
- Each write is queued, converted from (x, y) to a linear address (y*COLS + x), then written to the RAM when the scan-out arbiter grants the port.
- Sits between the I2C register interface and the text RAM arbiter, on the same clock as the video pipeline.

Parameters:
- COLS, 80, text columns per row; matches TEXTCOLS_CHAR.
- ROWS, 30, text rows; matches TEXTROWS_CHAR.
- ADDR_WIDTH, 12, RAM address width; COLS*ROWS must be ≤ 2^ADDR_WIDTH.
- FIFO_DEPTH, 4, queued writes; power of 2, ≥ 2.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- char_wr  in  1  single-cycle strobe: one character to commit.
- char_in  in  8  character code, sampled with char_wr.
- x_in  in  8  column, sampled with char_wr.
- y_in  in  8  row, sampled with char_wr.
- attr1_in  in  8  attribute byte 1, sampled with char_wr.
- attr2_in  in  8  attribute byte 2, sampled with char_wr.
- clear_req  in  1  single-cycle strobe: fill screen (see Optional Feature).
- mem_gnt  in  1  arbiter grant for the RAM write port.
- mem_req  out  1  RAM port request.
- mem_we  out  1  RAM write enable, one cycle per word.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_data  out  24  {attr2, attr1, char}.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- overflow  out  1  sticky: a char_wr was lost because the FIFO was full.
- drop_count  out  8  saturating count of out-of-range entries discarded.

Behaviour:
- Reset (async, reset_n=0):
  - FSM goes to IDLE; FIFO empties.
  - mem_req, mem_we, busy and overflow go to 0.
  - mem_addr, mem_data and drop_count go to 0.
- FIFO write:
  - char_wr pushes {char, x, y, attr1, attr2} at the sampling edge; the entry is visible to the FSM the next cycle.
  - If the FIFO is full: the entry is discarded and overflow is set to 1.
  - overflow stays 1 until reset.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
- FSM states:
  - IDLE:
    - Pending clear has priority (see Optional Feature).
    - Otherwise, if the FIFO is non-empty, pop the head into working registers.
    - If x ≥ COLS or y ≥ ROWS: drop the entry, increment drop_count (saturate at 255), stay in IDLE. The next entry may be popped the next cycle.
    - Otherwise go to MUL.
  - MUL:
    - Exactly 8 cycles of shift-add computing y*COLS, then + x.
    - Arithmetic is ADDR_WIDTH bits wide and never overflows for valid inputs.
    - Goes to REQ.
  - REQ:
    - mem_req=1; mem_addr and mem_data are driven stable.
    - On a cycle where mem_gnt=1, go to WRITE. Otherwise hold indefinitely.
  - WRITE:
    - mem_we=1 for exactly one cycle; mem_req stays 1.
    - Returns to IDLE; mem_req and mem_we fall the next cycle.
- Latency: char_wr at edge T, FIFO empty, FSM idle, mem_gnt tied high → mem_we high in cycle T+11.
- Throughput: one write per 11 cycles with mem_gnt held high.
- Ordering: FIFO order is preserved; no reordering or merging.
- The FIFO keeps accepting char_wr during MUL, REQ, WRITE and CLR.
- mem_gnt is ignored outside REQ and CLR.
- Reset asserted mid-write aborts the write; the RAM write is not completed, and the queued entries are lost.

Optional Feature:
- Macro: TEXT_WRITER_CLEAR_EN.
- Defined:
  - clear_req latches a pending-clear flag.
  - In IDLE, a pending clear takes priority over the FIFO; the FSM enters CLR and the flag is cleared.
  - CLR: mem_req=1. Each cycle with mem_gnt=1 asserts mem_we with mem_addr=counter and mem_data={attr2_in, attr1_in, 8'h20} sampled on entry to CLR, then increments the counter.
  - After address COLS*ROWS-1 is written, the FSM returns to IDLE.
  - clear_req arriving during CLR is latched and runs again afterwards.
- Undefined: clear_req is ignored, the CLR state does not exist, and the pending-clear flag is absent.

Test Plan:
- COLS=80, gnt high; char_wr with char=0x41, x=5, y=2, attr1=0x07, attr2=0x00 at T → mem_we only at T+11, addr=165, data=0x000741.
- Push 0x41, 0x42, 0x43 on 3 consecutive cycles, gnt high → three mem_we in order, data low bytes 0x41, 0x42, 0x43, addrs as computed, overflow=0.
- Hold gnt low, issue 5 char_wr (DEPTH=4) → overflow=1 after the 5th. Release gnt → exactly the first 4 writes appear.
- char_wr with x=80, y=0, then x=0, y=30 → no mem_we, drop_count=2, busy returns to 0.
- gnt held low for 20 cycles in REQ → mem_req=1 throughout, mem_we=0, addr/data stable. gnt high → one mem_we.
- TEXT_WRITER_CLEAR_EN defined, gnt high, clear_req → 2400 consecutive mem_we at addrs 0..2399 with char 0x20, then IDLE.
- Reset pulse during REQ → all outputs 0 and FIFO empty immediately.

Source files
------------

// File: rtl/text_ram_writer.sv
// text_ram_writer: queues character writes from the I2C register block,
// converts (x, y) to a linear text RAM address (y*COLS + x) with a
// multi-cycle shift-add, and commits each word once the arbiter grants.
// Optional screen-fill is compiled in with TEXT_WRITER_CLEAR_EN.
//
// state | meaning
// IDLE  | pending clear or pop FIFO head; out-of-range entries dropped here
// MUL   | 8 shift-add cycles forming y*COLS + x in mem_addr_q
// REQ   | mem_req high, address/data stable, wait for mem_gnt
// WRITE | one mem_we cycle, then back to IDLE
// CLR   | fill every cell with a space; one word per granted cycle
module text_ram_writer #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  char_wr,
    input  logic [7:0]            char_in,
    input  logic [7:0]            x_in,
    input  logic [7:0]            y_in,
    input  logic [7:0]            attr1_in,
    input  logic [7:0]            attr2_in,
    input  logic                  clear_req,
    input  logic                  mem_gnt,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [23:0]           mem_data,
    output logic                  busy,
    output logic                  overflow,
    output logic [7:0]            drop_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [31:0] COLS_W = COLS;
    localparam logic [31:0] ROWS_W = ROWS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
`ifdef TEXT_WRITER_CLEAR_EN
    localparam logic [2:0] S_CLR   = 3'd4;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COLS * ROWS - 1);
`endif

    logic [39:0]           fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        count_q;
    logic                  overflow_q;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [23:0]           mem_data_q, mem_data_d;
    logic [ADDR_WIDTH-1:0] mcand_q, mcand_d;
    logic [7:0]            mplier_q, mplier_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [7:0]            drop_q, drop_d;

    logic        fifo_empty, fifo_full, pop, push, clr_go, in_range;
    logic [39:0] head;
    logic [7:0]  h_char, h_x, h_y, h_a1, h_a2;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign head       = fifo_q[rd_ptr_q];
    assign h_char     = head[39:32];
    assign h_x        = head[31:24];
    assign h_y        = head[23:16];
    assign h_a1       = head[15:8];
    assign h_a2       = head[7:0];
    assign in_range   = ({24'd0, h_x} < COLS_W) && ({24'd0, h_y} < ROWS_W);

    assign pop  = (state_q == S_IDLE) && !clr_go && !fifo_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push = char_wr && (!fifo_full || pop);

`ifdef TEXT_WRITER_CLEAR_EN
    logic clr_pend_q;
    assign clr_go = clr_pend_q;

    // Latch clear requests; consumed when IDLE hands over to CLR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            clr_pend_q <= 1'b0;
        else if (clear_req)
            clr_pend_q <= 1'b1;
        else if (state_q == S_IDLE)
            clr_pend_q <= 1'b0;
    end
`else
    logic unused_clear;
    assign clr_go       = 1'b0;
    assign unused_clear = clear_req;
`endif

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= {char_in, x_in, y_in, attr1_in, attr2_in};
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
            if (char_wr && !push)
                overflow_q <= 1'b1;
        end
    end

    // Next-state and datapath decode for the sequencing FSM.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        case (state_q)
            S_IDLE: begin
                if (clr_go) begin
`ifdef TEXT_WRITER_CLEAR_EN
                    state_d    = S_CLR;
                    mem_addr_d = '0;
                    mem_data_d = {attr2_in, attr1_in, 8'h20};
`endif
                end else if (!fifo_empty) begin
                    if (in_range) begin
                        // Accumulator starts at x so the product lands on y*COLS + x.
                        mem_addr_d = ADDR_WIDTH'(h_x);
                        mem_data_d = {h_a2, h_a1, h_char};
                        mcand_d    = ADDR_WIDTH'(COLS);
                        mplier_d   = h_y;
                        cnt_d      = 3'd7;
                        state_d    = S_MUL;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                end
            end
            S_MUL: begin
                if (mplier_q[0])
                    mem_addr_d = mem_addr_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == 3'd0)
                    state_d = S_REQ;
                else
                    cnt_d = cnt_q - 3'd1;
            end
            S_REQ: begin
                if (mem_gnt)
                    state_d = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
`ifdef TEXT_WRITER_CLEAR_EN
            S_CLR: begin
                if (mem_gnt) begin
                    if (mem_addr_q == LAST_ADDR)
                        state_d = S_IDLE;
                    else
                        mem_addr_d = mem_addr_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and working registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
        end
    end

`ifdef TEXT_WRITER_CLEAR_EN
    assign mem_req = (state_q == S_REQ) || (state_q == S_WRITE) || (state_q == S_CLR);
    assign mem_we  = (state_q == S_WRITE) || ((state_q == S_CLR) && mem_gnt);
`else
    assign mem_req = (state_q == S_REQ) || (state_q == S_WRITE);
    assign mem_we  = (state_q == S_WRITE);
`endif
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_text_ram_writer.sv
// Directed bench for text_ram_writer (default COLS=80, ROWS=30, DEPTH=4).
module tb_text_ram_writer;

    logic        clk;
    logic        reset_n;
    logic        char_wr;
    logic [7:0]  char_in, x_in, y_in, attr1_in, attr2_in;
    logic        clear_req;
    logic        mem_gnt;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [23:0] mem_data;
    logic        busy, overflow;
    logic [7:0]  drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_push;

    int we_addr[$];
    int we_data[$];
    int we_cyc[$];

    text_ram_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .char_wr    (char_wr),
        .char_in    (char_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .attr1_in   (attr1_in),
        .attr2_in   (attr2_in),
        .clear_req  (clear_req),
        .mem_gnt    (mem_gnt),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .busy       (busy),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every RAM write strobe together with the cycle it occurred in.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            we_addr.push_back(int'(mem_addr));
            we_data.push_back(int'(mem_data));
            we_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] c, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] a1, input logic [7:0] a2);
        @(negedge clk);
        char_in  = c;
        x_in     = x;
        y_in     = y;
        attr1_in = a1;
        attr2_in = a2;
        char_wr  = 1'b1;
        t_push   = cyc;
    endtask

    task automatic push_end();
        @(negedge clk);
        char_wr = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        we_addr.delete();
        we_data.delete();
        we_cyc.delete();
    endtask

    initial begin
        reset_n   = 1'b0;
        char_wr   = 1'b0;
        char_in   = '0;
        x_in      = '0;
        y_in      = '0;
        attr1_in  = '0;
        attr2_in  = '0;
        clear_req = 1'b0;
        mem_gnt   = 1'b1;

        // Reset values
        wait_cycles(3);
        check("rst_mem_req",  int'(mem_req), 0);
        check("rst_mem_we",   int'(mem_we), 0);
        check("rst_busy",     int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_addr",     int'(mem_addr), 0);
        check("rst_data",     int'(mem_data), 0);
        check("rst_drop",     int'(drop_count), 0);
        reset_n = 1'b1;
        wait_cycles(2);

        // Single write: latency 11, addr 2*80+5
        clear_log();
        push(8'h41, 8'd5, 8'd2, 8'h07, 8'h00);
        push_end();
        wait_cycles(20);
        check("t1_count", we_addr.size(), 1);
        if (we_addr.size() >= 1) begin
            check("t1_latency", we_cyc[0] - t_push, 11);
            check("t1_addr", we_addr[0], 165);
            check("t1_data", we_data[0], 24'h000741);
        end
        check("t1_busy", int'(busy), 0);

        // Three back-to-back pushes, spaced 11 cycles apart on the RAM side
        clear_log();
        push(8'h41, 8'd1,  8'd0,  8'h11, 8'h22);
        push(8'h42, 8'd79, 8'd29, 8'h11, 8'h22);
        push(8'h43, 8'd0,  8'd1,  8'h11, 8'h22);
        push_end();
        wait_cycles(45);
        check("t2_count", we_addr.size(), 3);
        if (we_addr.size() == 3) begin
            check("t2_addr0", we_addr[0], 1);
            check("t2_addr1", we_addr[1], 2399);
            check("t2_addr2", we_addr[2], 80);
            check("t2_data0", we_data[0], 24'h221141);
            check("t2_data1", we_data[1], 24'h221142);
            check("t2_data2", we_data[2], 24'h221143);
            check("t2_spacing", we_cyc[1] - we_cyc[0], 11);
        end
        check("t2_overflow", int'(overflow), 0);

        // Out-of-range entries are dropped
        clear_log();
        push(8'h55, 8'd80, 8'd0,  8'h00, 8'h00);
        push(8'h56, 8'd0,  8'd30, 8'h00, 8'h00);
        push_end();
        wait_cycles(6);
        check("t3_no_we", we_addr.size(), 0);
        check("t3_drop", int'(drop_count), 2);
        check("t3_busy", int'(busy), 0);

        // Stall in REQ with grant low, then fill the FIFO past capacity
        clear_log();
        mem_gnt = 1'b0;
        push(8'h50, 8'd10, 8'd3, 8'h0F, 8'hA5);
        push_end();
        wait_cycles(12);
        for (int i = 0; i < 20; i++) begin
            check("t4_req",  int'(mem_req), 1);
            check("t4_we",   int'(mem_we), 0);
            check("t4_addr", int'(mem_addr), 250);
            check("t4_data", int'(mem_data), 24'hA50F50);
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("t4_ovf_before", int'(overflow), 0);
            push(8'h61 + 8'(i), 8'(i), 8'd0, 8'h00, 8'h00);
        end
        push_end();
        check("t4_ovf_after", int'(overflow), 1);
        check("t4_busy", int'(busy), 1);
        check("t4_no_we_yet", we_addr.size(), 0);
        mem_gnt = 1'b1;
        wait_cycles(70);
        check("t4_count", we_addr.size(), 5);
        if (we_addr.size() == 5) begin
            check("t4_addr_a", we_addr[0], 250);
            check("t4_data_a", we_data[0], 24'hA50F50);
            for (int i = 1; i < 5; i++) begin
                check("t4_addr_q", we_addr[i], i - 1);
                check("t4_data_q", we_data[i], 24'h000060 + i);
            end
        end
        check("t4_ovf_sticky", int'(overflow), 1);

        // Reset asserted while parked in REQ with a queued entry
        clear_log();
        mem_gnt = 1'b0;
        push(8'h70, 8'd7, 8'd1, 8'h33, 8'h44);
        push(8'h71, 8'd8, 8'd1, 8'h33, 8'h44);
        push_end();
        wait_cycles(14);
        check("t5_req_pre", int'(mem_req), 1);
        check("t5_busy_pre", int'(busy), 1);
        check("t5_addr_pre", int'(mem_addr), 87);
        reset_n = 1'b0;
        #1;
        check("t5_req",      int'(mem_req), 0);
        check("t5_we",       int'(mem_we), 0);
        check("t5_busy",     int'(busy), 0);
        check("t5_overflow", int'(overflow), 0);
        check("t5_addr",     int'(mem_addr), 0);
        check("t5_data",     int'(mem_data), 0);
        check("t5_drop",     int'(drop_count), 0);
        wait_cycles(2);
        reset_n = 1'b1;
        mem_gnt = 1'b1;
        wait_cycles(30);
        check("t5_no_we", we_addr.size(), 0);
        check("t5_busy_post", int'(busy), 0);

`ifdef TEXT_WRITER_CLEAR_EN
        // Screen fill: 2400 consecutive writes of a space
        begin
            int bad;
            clear_log();
            attr1_in = 8'h1E;
            attr2_in = 8'h00;
            @(negedge clk);
            clear_req = 1'b1;
            @(negedge clk);
            clear_req = 1'b0;
            wait_cycles(2410);
            check("t6_count", we_addr.size(), 2400);
            bad = 0;
            for (int i = 0; i < we_addr.size(); i++) begin
                if (we_addr[i] != i || we_data[i] != 24'h001E20) bad++;
                if (i > 0 && we_cyc[i] != we_cyc[i-1] + 1) bad++;
            end
            check("t6_words", bad, 0);
            check("t6_busy", int'(busy), 0);
        end
`else
        // clear_req has no effect when the fill feature is not built
        clear_log();
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        wait_cycles(10);
        check("t6_no_we", we_addr.size(), 0);
        check("t6_no_req", int'(mem_req), 0);
        check("t6_busy", int'(busy), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
